calc_core: RTL and testbench

//  Parametrised successor of the 4-digit calculator: NDIGITS-digit decimal

---
 rtl/calc_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_calc_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core.sv
// Decimal calculator core with a signed accumulator, valid/ready command intake,
// serial binary-to-BCD conversion and a time-multiplexed digit scanner.
module calc_core #(
    parameter int NDIGITS  = 8,
    parameter int WIDTH    = 27,
    parameter int SCAN_DIV = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         cmd,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [1:0]         status,
    output logic               neg,
    output logic [3:0]         data,
    output logic [NDIGITS-1:0] pos
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10,
        ERROR   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_SHIFT,
        CV_COMMIT
    } cv_t;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int RW  = 2 * WIDTH + 2;
    localparam int BW  = 4 * NDIGITS;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int SCW = $clog2(SCAN_DIV + 1);

    localparam logic [WIDTH-1:0]     ENTRY_FULL = WIDTH'(pow10(NDIGITS - 1));
    localparam logic signed [RW-1:0] MAX_POS    = RW'(pow10(NDIGITS) - 1);
    localparam logic signed [RW-1:0] MIN_NEG    = RW'(-(pow10(NDIGITS - 1) - 1));
    localparam logic [SCW-1:0]       SC_LAST    = SCW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]        BIT_LAST   = CW'(WIDTH - 1);

    // calculator state
    mode_t                   mode, mode_nx;
    op_t                     op, op_nx, op_new;
    logic signed [WIDTH:0]   acc, acc_nx;
    logic [WIDTH-1:0]        entry, entry_nx;

    // arithmetic
    logic signed [RW-1:0]    a_ext, b_ext, res;
    logic                    ovf;

    // conversion and display
    cv_t                     cv, cv_nx;
    logic [CW-1:0]           bitcnt;
    logic [WIDTH-1:0]        mag_nx, bin;
    logic                    neg_nx, conv_neg, disp_neg;
    mode_t                   conv_mode, disp_mode;
    logic [BW-1:0]           bcd, bcd_adj, disp_bcd;
    logic [SCW-1:0]          scnt;
    int unsigned             msd;
    logic                    accept;

    assign cmd_ready = (cv == CV_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign status    = disp_mode;
    assign neg       = disp_neg;

    always_comb begin
        a_ext = RW'(acc);
        b_ext = signed'(RW'(entry));
        case (op)
            OP_ADD:  res = a_ext + b_ext;
            OP_SUB:  res = a_ext - b_ext;
            OP_MUL:  res = a_ext * b_ext;
            default: res = b_ext;
        endcase
        ovf = (res > MAX_POS) || (res < MIN_NEG);
    end

    always_comb begin
        mode_nx  = mode;
        op_nx    = op;
        acc_nx   = acc;
        entry_nx = entry;
        op_new   = (cmd == 4'hA) ? OP_ADD : (cmd == 4'hB) ? OP_SUB : OP_MUL;

        if (cmd == 4'hF) begin
            mode_nx  = ENTER_A;
            op_nx    = OP_NONE;
            acc_nx   = '0;
            entry_nx = '0;
        end else if (mode != ERROR) begin
            if (cmd <= 4'd9) begin
                if (mode == SHOW) begin
                    entry_nx = WIDTH'(cmd);
                    mode_nx  = ENTER_A;
                    op_nx    = OP_NONE;
                end else if (entry < ENTRY_FULL) begin
                    entry_nx = entry * WIDTH'(10) + WIDTH'(cmd);
                end
            end else begin
                case (cmd)
                    4'hA, 4'hB, 4'hC: begin
                        entry_nx = '0;
                        mode_nx  = ENTER_B;
                        op_nx    = op_new;
                        if (mode == ENTER_A) begin
                            acc_nx = {1'b0, entry};
                        end else if (mode == ENTER_B) begin
                            // chained operator: finish the pending op first
                            if (ovf) mode_nx = ERROR;
                            else     acc_nx  = res[WIDTH:0];
                        end
                    end
                    4'hD: entry_nx = entry / WIDTH'(10);
                    4'hE: begin
                        if (mode == ENTER_A) begin
                            acc_nx   = {1'b0, entry};
                            entry_nx = '0;
                            op_nx    = OP_NONE;
                            mode_nx  = SHOW;
                        end else if (mode == ENTER_B) begin
                            if (ovf) begin
                                mode_nx = ERROR;
                            end else begin
                                acc_nx   = res[WIDTH:0];
                                entry_nx = '0;
                                op_nx    = OP_NONE;
                                mode_nx  = SHOW;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (mode_nx == SHOW) begin
            neg_nx = acc_nx[WIDTH];
            mag_nx = acc_nx[WIDTH] ? WIDTH'(-acc_nx) : WIDTH'(acc_nx);
        end else if (mode_nx == ERROR) begin
            neg_nx = 1'b0;
            mag_nx = '0;
        end else begin
            neg_nx = 1'b0;
            mag_nx = entry_nx;
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) cv <= CV_IDLE;
        else        cv <= cv_nx;
    end

    always_comb begin
        cv_nx = cv;
        case (cv)
            CV_IDLE:   if (accept) cv_nx = CV_SHIFT;
            CV_SHIFT:  if (bitcnt == BIT_LAST) cv_nx = CV_COMMIT;
            CV_COMMIT: cv_nx = CV_IDLE;
            default:   cv_nx = CV_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode      <= ENTER_A;
            op        <= OP_NONE;
            acc       <= '0;
            entry     <= '0;
            bin       <= '0;
            bcd       <= '0;
            bitcnt    <= '0;
            conv_neg  <= 1'b0;
            conv_mode <= ENTER_A;
            disp_bcd  <= '0;
            disp_neg  <= 1'b0;
            disp_mode <= ENTER_A;
        end else if (accept) begin
            // state updates at once; the display catches up after the conversion
            mode      <= mode_nx;
            op        <= op_nx;
            acc       <= acc_nx;
            entry     <= entry_nx;
            bin       <= mag_nx;
            bcd       <= '0;
            bitcnt    <= '0;
            conv_neg  <= neg_nx;
            conv_mode <= mode_nx;
        end else if (cv == CV_SHIFT) begin
            bcd    <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
            bin    <= {bin[WIDTH-2:0], 1'b0};
            bitcnt <= bitcnt + CW'(1);
        end else if (cv == CV_COMMIT) begin
            disp_bcd  <= bcd;
            disp_neg  <= conv_neg;
            disp_mode <= conv_mode;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            scnt <= '0;
            pos  <= NDIGITS'(1);
        end else if (scnt == SC_LAST) begin
            scnt <= '0;
            pos  <= {pos[NDIGITS-2:0], pos[NDIGITS-1]};
        end else begin
            scnt <= scnt + SCW'(1);
        end
    end

    always_comb begin
        msd = 0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) msd = i;
        end
        data = 4'hF;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (pos[i]) begin
                if (disp_mode == ERROR)           data = 4'hE;
                else if (i <= msd)                data = disp_bcd[4*i +: 4];
                else if (disp_neg && i == msd + 1) data = 4'hA;
            end
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// Vector table of commands with expected status/value, checked through a
// scoreboard queue when the core reports ready again; plus handshake/reset sequences.
module tb_calc_core;

    localparam int N  = 8;
    localparam int W  = 27;
    localparam int SD = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [3:0]   cmd = 4'h0;
    logic         cmd_ready;
    logic [1:0]   status;
    logic         neg;
    logic [3:0]   data;
    logic [N-1:0] pos;

    always #5 clock = ~clock;

    calc_core #(.NDIGITS(N), .WIDTH(W), .SCAN_DIV(SD)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .status   (status),
        .neg      (neg),
        .data     (data),
        .pos      (pos)
    );

    typedef struct {
        logic [3:0] cmd;
        logic [1:0] st;
        longint     val;
    } vec_t;

    vec_t vt[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4*N-1:0] exp_disp(input logic [1:0] st, input longint val);
        logic [4*N-1:0] r;
        logic [3:0]     d[N];
        longint         m;
        int             msd;
        if (st == 2'b11) return {N{4'hE}};
        m   = (val < 0) ? -val : val;
        msd = 0;
        for (int i = 0; i < N; i++) begin
            d[i] = 4'(m % 10);
            m    = m / 10;
            if (d[i] != 4'd0) msd = i;
        end
        for (int i = 0; i < N; i++) begin
            if (i <= msd)                      r[4*i +: 4] = d[i];
            else if (val < 0 && i == msd + 1)  r[4*i +: 4] = 4'hA;
            else                               r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction

    task automatic read_disp(output logic [4*N-1:0] v);
        logic [N-1:0] seen;
        seen = '0;
        v    = '0;
        for (int k = 0; k < N * SD + 4 && seen != {N{1'b1}}; k++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (pos[i]) begin
                    v[4*i +: 4] = data;
                    seen[i]     = 1'b1;
                end
            end
        end
        if (seen != {N{1'b1}}) chk("scan_coverage", 64'(seen), 64'({N{1'b1}}));
    endtask

    task automatic check_view(input string tag, input logic [1:0] st, input longint val);
        logic [4*N-1:0] dv;
        chk($sformatf("%s status", tag), 64'(status), 64'(st));
        chk($sformatf("%s neg", tag), 64'(neg), 64'(st == 2'b10 && val < 0));
        read_disp(dv);
        chk($sformatf("%s display", tag), 64'(dv), 64'(exp_disp(st, val)));
    endtask

    // called at a negedge; returns at a negedge
    task automatic send(input vec_t v, input int idx);
        int   waitc;
        int   low;
        vec_t e;
        waitc = 0;
        low   = 0;
        while (!cmd_ready && waitc < 200) begin
            @(negedge clock);
            waitc++;
        end
        if (!cmd_ready) chk($sformatf("v%0d ready_wait", idx), 64'(cmd_ready), 64'd1);
        cmd       = v.cmd;
        cmd_valid = 1'b1;
        exp_q.push_back(v);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd       = 4'h0;
        while (!cmd_ready && low < 200) begin
            low++;
            @(negedge clock);
        end
        chk($sformatf("v%0d latency", idx), 64'(low), 64'(W + 1));
        e = exp_q.pop_front();
        check_view($sformatf("v%0d cmd %0h", idx, e.cmd), e.st, e.val);
    endtask

    task automatic add(input logic [3:0] c, input logic [1:0] st, input longint val);
        vt.push_back('{cmd: c, st: st, val: val});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           bad;
        int           accepts;
        longint       v;
        logic [N-1:0] ep;

        // reset state
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset ready", 64'(cmd_ready), 64'd1);
        chk("reset status", 64'(status), 64'd0);
        chk("reset neg", 64'(neg), 64'd0);
        chk("reset pos", 64'(pos), 64'd1);
        chk("reset data", 64'(data), 64'd0);
        reset = 1'b1;

        // 12 + 7 = 19
        add(4'h1, 2'b00, 1); add(4'h2, 2'b00, 12); add(4'hA, 2'b01, 0);
        add(4'h7, 2'b01, 7); add(4'hE, 2'b10, 19);
        // 1 - 10 = -9, then * 3 = -27, backspace in SHOW leaves it
        add(4'h1, 2'b00, 1); add(4'hB, 2'b01, 0); add(4'h1, 2'b01, 1);
        add(4'h0, 2'b01, 10); add(4'hE, 2'b10, -9); add(4'hC, 2'b01, 0);
        add(4'h3, 2'b01, 3); add(4'hE, 2'b10, -27); add(4'hD, 2'b10, -27);
        // 99999999 * 2 overflows; digits ignored in ERROR; clear recovers
        add(4'hF, 2'b00, 0);
        v = 0;
        for (int i = 0; i < N; i++) begin
            v = v * 10 + 9;
            add(4'h9, 2'b00, v);
        end
        add(4'hC, 2'b01, 0); add(4'h2, 2'b01, 2); add(4'hE, 2'b11, 0);
        add(4'h5, 2'b11, 0); add(4'hF, 2'b00, 0);
        // ninth digit ignored, backspace twice, chain 999999 + 1
        v = 0;
        for (int i = 0; i < N; i++) begin
            v = v * 10 + 9;
            add(4'h9, 2'b00, v);
        end
        add(4'h9, 2'b00, 99999999); add(4'hD, 2'b00, 9999999); add(4'hD, 2'b00, 999999);
        add(4'hA, 2'b01, 0); add(4'h1, 2'b01, 1); add(4'hA, 2'b01, 0);
        add(4'hE, 2'b10, 1000000);
        // most negative displayable result, then one past it
        add(4'hF, 2'b00, 0); add(4'h1, 2'b00, 1); add(4'hB, 2'b01, 0);
        add(4'h1, 2'b01, 1);
        v = 1;
        for (int i = 0; i < N - 1; i++) begin
            v = v * 10;
            add(4'h0, 2'b01, v);
        end
        add(4'hE, 2'b10, -9999999); add(4'hB, 2'b01, 0); add(4'h1, 2'b01, 1);
        add(4'hE, 2'b11, 0); add(4'hF, 2'b00, 0);
        // equals from ENTER_A, repeated equals, operator from SHOW
        add(4'h4, 2'b00, 4); add(4'h2, 2'b00, 42); add(4'hE, 2'b10, 42);
        add(4'hE, 2'b10, 42); add(4'hA, 2'b01, 0); add(4'h8, 2'b01, 8);
        add(4'hE, 2'b10, 50); add(4'hF, 2'b00, 0);

        @(negedge clock);
        for (int i = 0; i < vt.size(); i++) send(vt[i], i);

        // held valid: one accept per W+2 cycles, ready low W+1 cycles
        cmd       = 4'h3;
        cmd_valid = 1'b1;
        bad       = 0;
        accepts   = 0;
        for (int k = 0; k < 3 * (W + 2); k++) begin
            if (cmd_ready) accepts++;
            if (cmd_ready !== ((k % (W + 2)) == 0)) bad++;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk("hold ready_pattern_errors", 64'(bad), 64'd0);
        chk("hold accepts", 64'(accepts), 64'd3);
        chk("hold ready_back", 64'(cmd_ready), 64'd1);
        check_view("hold", 2'b00, 333);

        // reset in the middle of a conversion
        cmd       = 4'h4;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset ready", 64'(cmd_ready), 64'd1);
        chk("midreset status", 64'(status), 64'd0);
        chk("midreset neg", 64'(neg), 64'd0);
        chk("midreset pos", 64'(pos), 64'd1);
        chk("midreset data", 64'(data), 64'd0);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k <= N * SD; k++) begin
            ep = N'(1) << ((k / SD) % N);
            if (pos !== ep) bad++;
            @(negedge clock);
        end
        chk("scan walk_errors", 64'(bad), 64'd0);
        chk("midreset ready_stays", 64'(cmd_ready), 64'd1);
        check_view("midreset", 2'b00, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
